pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the architectural PC of the multicycle MIPS core.
- Resolves branches and jumps from decoded fields, register operands and the extended/shifted immediate supplied by the sign-extension stage.
- Implements the one-instruction branch delay slot, link-address generation and the halt-on-jump-to-zero rule.
- Sits between decode/register-read and the instruction-fetch bus master, advancing only when the current instruction retires.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, control-transfer target that halts the CPU.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- retire  in  1  current instruction completes this cycle; PC may advance
- opcode  in  6  instr[31:26]
- rt_field  in  5  instr[20:16]; REGIMM sub-op
- funct  in  6  instr[5:0]
- rs_data  in  32  GPR[rs]
- rt_data  in  32  GPR[rt]
- branch_offset  in  32  sign-extended immediate, already shifted left by 2
- jump_index  in  26  instr[25:0]
- pc  out  32  address of current instruction
- active  out  1  high while the CPU executes
- link_en  out  1  comb.: current instruction writes a link register
- link_addr  out  32  comb.: pc+8
- in_delay_slot  out  1  current instruction is a delay-slot instruction
- misaligned_fault  out  1  sticky fault flag (Optional Feature)

Behaviour:
- Reset (sync, any state, including mid-delay-slot): pc=RESET_VECTOR, state=RUN, pending_target=0, active=1, in_delay_slot=0, misaligned_fault=0.
- States: RUN, DELAY, HALTED. Encoded as a 2-bit enum. in_delay_slot is high exactly in DELAY.
- Registers change only on clk edges with retire=1. retire=0 holds all state (stall).
- RUN, retire=1, transfer taken: pending_target<=target; pc<=pc+4; state<=DELAY.
- RUN, retire=1, not taken: pc<=pc+4.
- DELAY, retire=1, pending_target==HALT_ADDR: state<=HALTED, active<=0, pc unchanged.
- DELAY, retire=1, otherwise: pc<=pending_target, state<=RUN.
- Any branch or jump decoded in DELAY is ignored. It never causes a transfer and link_en stays 0 (architecturally undefined; suppressed).
- HALTED: all inputs ignored, active=0, pc frozen. Only reset exits HALTED.
- Branch target = pc+4+branch_offset, mod 2^32 with wrap-around.
- J/JAL target = {pc_plus4[31:28], jump_index, 2'b00}.
- JR/JALR target = rs_data.
- Conditions, with signed compares:
  - BEQ: rs==rt
  - BNE: rs!=rt
  - BGTZ: rs>0
  - BLEZ: rs<=0
  - REGIMM with rt_field 0x00 BLTZ, 0x01 BGEZ, 0x10 BLTZAL, 0x11 BGEZAL
  - J, JAL, JR, JALR: always taken
- Any other REGIMM rt_field is not a transfer.
- link_en=1 in RUN for JAL, JALR, BLTZAL and BGEZAL. For the AL branches it asserts regardless of whether the branch is taken.
- Transfer to HALT_ADDR: the delay slot still executes, then the halt takes effect.

Optional Feature:
- Macro: PC_SEQ_ALIGN_CHECK_EN.
- Enabled: a taken JR/JALR with rs_data[1:0]!=0 sets misaligned_fault<=1 at the delay-slot retire instead of loading pc. State goes to HALTED with active=0. The fault is sticky until reset.
- Disabled: misaligned_fault tied 0; the target loads unmodified.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OPCODE_BEQ/BNE/BGTZ/BLEZ/REGIMM/J/JAL/SPECIAL)
  - FUNCT_JR/FUNCT_JALR
  - REGIMM_BLTZ/BGEZ/BLTZAL/BGEZAL
  - the pc_seq_state_t enum
  - RESET_VECTOR default
- Sub-module branch_condition (combinational) takes opcode, rt_field, funct, rs_data and rt_data. Outputs: is_transfer, taken, is_link, target_sel.

Test Plan:
- Reset, retire=1 with NOP x3 -> pc 0xBFC00000, 0xBFC00004, 0xBFC00008; active=1.
- At pc=0xBFC00010: BEQ with rs=rt=5, offset=0xFFFFFFF0 -> next pc 0xBFC00014 with in_delay_slot=1, then 0xBFC00004.
- BLTZAL with rs=1 at pc=0xBFC00020 -> link_en=1, link_addr=0xBFC00028; not taken; next pc 0xBFC00024.
- JR with rs=0x00000000 -> delay slot at pc+4 executes; next retire gives active=0 and pc frozen; further retires do nothing; reset restores 0xBFC00000.
- retire=0 for 5 cycles in DELAY after a J -> pc/state unchanged; first retire=1 loads the J target.
- Ifdef PC_SEQ_ALIGN_CHECK_EN: JR with rs=0xBFC00102 -> misaligned_fault=1, active=0 after the delay slot. Without the macro, pc=0xBFC00102.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MIPS core definitions: opcode/funct/REGIMM encodings, PC sequencer state
// and target-select enums, plus default reset and halt addresses.
package cpu_pkg;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_REGIMM  = 6'h01;
  localparam logic [5:0] OPCODE_J       = 6'h02;
  localparam logic [5:0] OPCODE_JAL     = 6'h03;
  localparam logic [5:0] OPCODE_BEQ     = 6'h04;
  localparam logic [5:0] OPCODE_BNE     = 6'h05;
  localparam logic [5:0] OPCODE_BLEZ    = 6'h06;
  localparam logic [5:0] OPCODE_BGTZ    = 6'h07;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  localparam logic [4:0] REGIMM_BLTZ   = 5'h00;
  localparam logic [4:0] REGIMM_BGEZ   = 5'h01;
  localparam logic [4:0] REGIMM_BLTZAL = 5'h10;
  localparam logic [4:0] REGIMM_BGEZAL = 5'h11;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCS_RUN    = 2'b00,
    PCS_DELAY  = 2'b01,
    PCS_HALTED = 2'b10
  } pc_seq_state_t;

  typedef enum logic [1:0] {
    TGT_BRANCH = 2'b00,
    TGT_JUMP   = 2'b01,
    TGT_REG    = 2'b10
  } target_sel_t;

  // True for the REGIMM sub-ops that compare rs against zero.
  function automatic logic is_regimm_branch(input logic [4:0] rt_field);
    return (rt_field == REGIMM_BLTZ)   || (rt_field == REGIMM_BGEZ) ||
           (rt_field == REGIMM_BLTZAL) || (rt_field == REGIMM_BGEZAL);
  endfunction

endpackage

// File: rtl/branch_condition.sv
// Combinational control-transfer decoder: classifies the instruction, evaluates
// its signed condition and selects which target source applies.
module branch_condition
  import cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_field,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        is_transfer,
  output logic        taken,
  output logic        is_link,
  output target_sel_t target_sel
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_data[31];
  assign rs_zero = (rs_data == 32'd0);

  always_comb begin
    is_transfer = 1'b0;
    taken       = 1'b0;
    is_link     = 1'b0;
    target_sel  = TGT_BRANCH;
    case (opcode)
      OPCODE_SPECIAL: begin
        if ((funct == FUNCT_JR) || (funct == FUNCT_JALR)) begin
          is_transfer = 1'b1;
          taken       = 1'b1;
          is_link     = (funct == FUNCT_JALR);
          target_sel  = TGT_REG;
        end
      end
      OPCODE_J, OPCODE_JAL: begin
        is_transfer = 1'b1;
        taken       = 1'b1;
        is_link     = (opcode == OPCODE_JAL);
        target_sel  = TGT_JUMP;
      end
      OPCODE_BEQ: begin
        is_transfer = 1'b1;
        taken       = (rs_data == rt_data);
      end
      OPCODE_BNE: begin
        is_transfer = 1'b1;
        taken       = (rs_data != rt_data);
      end
      OPCODE_BLEZ: begin
        is_transfer = 1'b1;
        taken       = rs_neg || rs_zero;
      end
      OPCODE_BGTZ: begin
        is_transfer = 1'b1;
        taken       = !rs_neg && !rs_zero;
      end
      OPCODE_REGIMM: begin
        // Bit 0 of rt_field picks GEZ over LTZ; bit 4 marks the linking variants.
        if (is_regimm_branch(rt_field)) begin
          is_transfer = 1'b1;
          taken       = rt_field[0] ? !rs_neg : rs_neg;
          is_link     = rt_field[4];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: branch/jump resolution, one-instruction delay slot,
// link address and halt-on-jump-to-HALT_ADDR.
// Optional macro PC_SEQ_ALIGN_CHECK_EN: misaligned JR/JALR targets fault and halt.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rt_field,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic        active,
  output logic        link_en,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        misaligned_fault
);

  pc_seq_state_t state, state_next;
  target_sel_t   target_sel;

  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] pending_target;
  logic [31:0] pending_next;
  logic        is_transfer;
  logic        taken;
  logic        is_link;
  logic        take_now;
  logic        misalign_hit;

  branch_condition u_branch_condition (
    .opcode      (opcode),
    .rt_field    (rt_field),
    .funct       (funct),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .is_transfer (is_transfer),
    .taken       (taken),
    .is_link     (is_link),
    .target_sel  (target_sel)
  );

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    target = pc_plus4 + branch_offset;
    case (target_sel)
      TGT_JUMP: target = {pc_plus4[31:28], jump_index, 2'b00};
      TGT_REG:  target = rs_data;
      default:  target = pc_plus4 + branch_offset;
    endcase
  end

  // Transfers decoded inside a delay slot are suppressed, including their link.
  assign take_now      = (state == PCS_RUN) && is_transfer && taken;
  assign link_en       = (state == PCS_RUN) && is_link;
  assign link_addr     = pc + 32'd8;
  assign in_delay_slot = (state == PCS_DELAY);
  assign active        = (state != PCS_HALTED);

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic pending_misaligned;
  logic fault_q;

  // Remember the alignment of a taken register jump until its delay slot retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_misaligned <= 1'b0;
      fault_q            <= 1'b0;
    end else if (retire) begin
      if (state == PCS_RUN)
        pending_misaligned <= take_now && (target_sel == TGT_REG) && (rs_data[1:0] != 2'b00);
      if ((state == PCS_DELAY) && pending_misaligned)
        fault_q <= 1'b1;
    end
  end

  assign misalign_hit     = pending_misaligned;
  assign misaligned_fault = fault_q;
`else
  assign misalign_hit     = 1'b0;
  assign misaligned_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= PCS_RUN;
      pc             <= RESET_VECTOR;
      pending_target <= 32'd0;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      pending_target <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_target;
    if (retire) begin
      case (state)
        PCS_RUN: begin
          pc_next = pc_plus4;
          if (take_now) begin
            pending_next = target;
            state_next   = PCS_DELAY;
          end
        end
        PCS_DELAY: begin
          if (misalign_hit || (pending_target == HALT_ADDR)) begin
            state_next = PCS_HALTED;
          end else begin
            pc_next    = pending_target;
            state_next = PCS_RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
